flash_arbiter: RTL and testbench
================================

FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, flash byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, flash read-word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive ifetch grants while a data request waits.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports if_req in 1, if_addr in ADDR_W, if_valid out 1, if_rdata out DATA_W; the instruction-fetch requester.
REQ-007 SHALL have ports d_req in 1, d_addr in ADDR_W, d_valid out 1, d_rdata out DATA_W; the data-load requester.
REQ-008 SHALL have ports flash_rstrobe out 1, flash_addr out ADDR_W, flash_rbusy in 1, flash_rdata in DATA_W; the shared SPI flash reader.
REQ-009 SHALL have port if_first out 1, high while an ifetch transaction is in flight (the CPU stall source).

Function
REQ-010 Requester handshake SHALL be: req held high with stable addr until its valid pulses high for exactly one cycle; req still high in the cycle after valid is a new request.
REQ-011 FSM states SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE, RESP.
REQ-012 IDLE SHALL grant one pending requester, latch its address into flash_addr and an owner bit, then go to START.
REQ-013 Arbitration SHALL give ifetch priority, except that data wins when starve_cnt == STARVE_MAX.
REQ-014 starve_cnt SHALL increment on each ifetch grant made while d_req is high, saturate at STARVE_MAX, and clear on any data grant.
REQ-015 START SHALL assert flash_rstrobe for exactly one cycle, then go to WAIT_BUSY.
REQ-016 WAIT_BUSY SHALL stay until flash_rbusy == 1, then go to WAIT_DONE.
REQ-017 WAIT_DONE SHALL stay while flash_rbusy == 1; on the first cycle it is 0, it SHALL register flash_rdata into the owner's rdata and go to RESP.
REQ-018 RESP SHALL pulse the owner's valid for one cycle, then return to IDLE; re-arbitration SHALL happen in the following IDLE cycle (minimum one idle cycle between transactions).
REQ-019 if_rdata and d_rdata SHALL hold their last value until overwritten by a response to the same requester.
REQ-020 A req dropped mid-transaction SHALL NOT abort it; the transaction SHALL complete and valid SHALL still pulse.
REQ-021 flash_addr SHALL be stable from START through WAIT_DONE.
REQ-022 if_first SHALL be high from the ifetch grant cycle through RESP inclusive.

Reset
REQ-023 When rst_n is low: state = IDLE; flash_rstrobe, if_valid, d_valid, if_first = 0; if_rdata, d_rdata, flash_addr = 0; starve_cnt = 0; owner = ifetch.
REQ-024 Reset asserted mid-transaction SHALL abandon it with no valid pulse; a flash_rbusy still high after reset release SHALL be ignored in IDLE.

Configuration
REQ-025 Macro FLASH_ARB_IFETCH_CACHE_EN SHALL control a one-entry ifetch cache holding a tag, data and a valid bit.
REQ-026 With FLASH_ARB_IFETCH_CACHE_EN defined: an IDLE ifetch grant with a cache hit (valid and if_addr == tag) SHALL go directly to RESP with cached data, with no flash_rstrobe.
REQ-027 With FLASH_ARB_IFETCH_CACHE_EN defined: every flash-serviced ifetch SHALL fill the cache; reset SHALL clear the valid bit; a hit SHALL count as an ifetch grant for starve_cnt.
REQ-028 Without FLASH_ARB_IFETCH_CACHE_EN: no cache storage SHALL exist, and every ifetch SHALL access flash.

Verification
REQ-029 Single fetch: if_req=1, if_addr=0x400000, flash busy 3 cycles, rdata 0x00000013 -> one rstrobe with flash_addr=0x400000; if_valid one cycle with if_rdata=0x00000013; d_valid stays 0.
REQ-030 Simultaneous requests: if_req and d_req rise together, starve_cnt=0 -> ifetch served first; data served next at d_addr=0x400100.
REQ-031 Starvation: if_req held high continuously, d_req held high, STARVE_MAX=4 -> exactly 4 ifetch transactions, then 1 data transaction, then ifetch resumes.
REQ-032 Reset mid-op: rst_n pulsed low during WAIT_DONE -> no valid pulse; outputs at reset values; next request completes normally.
REQ-033 Cache (macro defined): two fetches to 0x400004 -> one rstrobe total; second if_valid arrives 2 cycles after request with identical data. Same test with macro undefined -> two rstrobes.
REQ-034 Dropped request: if_req deasserted during WAIT_BUSY -> transaction completes and if_valid pulses once.

Source files
------------

// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one SPI flash read port between the instruction-fetch
// and data-load requesters. Ifetch has priority, but a waiting data request is
// served after STARVE_MAX consecutive ifetch grants.
// Optional build macro FLASH_ARB_IFETCH_CACHE_EN adds a one-entry ifetch cache
// that answers a repeated fetch of the last flash-read address without
// touching flash.
module flash_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction-fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_first,
  // data-load requester
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  // shared flash reader
  output logic              flash_rstrobe,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic              flash_rbusy,
  input  logic [DATA_W-1:0] flash_rdata
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  logic [2:0]       state;
  logic             owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_if;
  logic             grant_d;
  logic             cache_hit;
  logic             read_done;

`ifdef FLASH_ARB_IFETCH_CACHE_EN
  logic              cache_valid;
  logic [ADDR_W-1:0] cache_tag;
  logic [DATA_W-1:0] cache_data;

  assign cache_hit = cache_valid && (if_addr == cache_tag);

  // Cache valid bit: cleared by reset, set by every flash-serviced ifetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
    end else if (read_done && owner == OWN_IF) begin
      cache_valid <= 1'b1;
    end
  end

  // Cache tag and data capture on each flash-serviced ifetch.
  // NOTE: tag/data are storage qualified by cache_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (read_done && owner == OWN_IF) begin
      cache_tag  <= flash_addr;
      cache_data <= flash_rdata;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Flash has returned the word: first WAIT_DONE cycle with busy low.
  assign read_done = (state == S_WAIT_DONE) && !flash_rbusy;

  // Arbitration in IDLE: ifetch first unless the data side has starved.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state == S_IDLE) begin
      if (d_req && (!if_req || starve_cnt == STARVE_LIM)) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  // Transaction FSM, address/owner latch, starvation counter and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      flash_addr <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state)
        S_IDLE: begin
          if (grant_d) begin
            owner      <= OWN_D;
            flash_addr <= d_addr;
            starve_cnt <= '0;
            state      <= S_START;
          end else if (grant_if) begin
            owner      <= OWN_IF;
            flash_addr <= if_addr;
            if (d_req && starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
`ifdef FLASH_ARB_IFETCH_CACHE_EN
            if (cache_hit) begin
              if_rdata <= cache_data;
              state    <= S_RESP;
            end else begin
              state    <= S_START;
            end
`else
            state <= S_START;
`endif
          end
        end
        S_START:     state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (flash_rbusy) state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (!flash_rbusy) begin
            if (owner == OWN_D) d_rdata  <= flash_rdata;
            else                if_rdata <= flash_rdata;
            state <= S_RESP;
          end
        end
        S_RESP:      state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state and owner; all are low in IDLE.
  assign flash_rstrobe = (state == S_START);
  assign if_valid      = (state == S_RESP) && (owner == OWN_IF);
  assign d_valid       = (state == S_RESP) && (owner == OWN_D);
  assign if_first      = (state != S_IDLE) && (owner == OWN_IF);

  // cache_hit is only consumed when the cache is built in.
  logic unused_hit;
  assign unused_hit = cache_hit;

endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: scoreboard bench for flash_arbiter. Requester drivers push
// expected read data; a behavioural flash model applies the arbitration rules
// at each read strobe and queues the expected owner; a monitor pops and
// compares whenever a valid pulses.
module tb_flash_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int STARVE = 4;
  localparam int TMO    = 400;
`ifdef FLASH_ARB_IFETCH_CACHE_EN
  localparam int EXP_CACHE_STROBES = 1;
`else
  localparam int EXP_CACHE_STROBES = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, d_req;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic              if_valid, d_valid, if_first;
  logic [DATA_W-1:0] if_rdata, d_rdata;
  logic              flash_rstrobe;
  logic [ADDR_W-1:0] flash_addr;
  logic              flash_rbusy = 1'b0;
  logic [DATA_W-1:0] flash_rdata = '0;

  flash_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .if_first(if_first),
    .d_req(d_req), .d_addr(d_addr), .d_valid(d_valid), .d_rdata(d_rdata),
    .flash_rstrobe(flash_rstrobe), .flash_addr(flash_addr),
    .flash_rbusy(flash_rbusy), .flash_rdata(flash_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe = 0;
  int fix_busy = 0;
  int fl_phase = 0;
  int fl_cnt = 0;
  int fl_blen = 0;
  int ref_starve = 0;
  logic [ADDR_W-1:0] fl_addr;
  logic [DATA_W-1:0] if_exp[$];
  logic [DATA_W-1:0] d_exp[$];
  bit                owner_q[$];
  bit                own_log[$];

  // Request state as seen at the most recent rising edge (the grant edge).
  logic              snap_if = 1'b0, snap_d = 1'b0;
  logic [ADDR_W-1:0] snap_ifa = '0, snap_da = '0;

  function automatic logic [DATA_W-1:0] fdat(input logic [ADDR_W-1:0] a);
    return {a[7:0], a} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    snap_if  <= if_req;
    snap_d   <= d_req;
    snap_ifa <= if_addr;
    snap_da  <= d_addr;
  end

  // Flash device model plus reference arbiter (decides who should own each strobe).
  always @(negedge clk) begin
    bit own;
    logic [ADDR_W-1:0] ea;
    if (!rst_n) begin
      fl_phase    = 3;
      fl_cnt      = 3;
      flash_rbusy = 1'b1;  // stale busy across reset must be ignored
      ref_starve  = 0;
    end else begin
      case (fl_phase)
        0: if (flash_rstrobe) begin
          n_strobe++;
          check("strobe_has_req", {31'd0, snap_if | snap_d}, 32'd1);
          if (snap_d && (!snap_if || ref_starve == STARVE)) begin
            own = 1'b1; ea = snap_da; ref_starve = 0;
          end else begin
            own = 1'b0; ea = snap_ifa;
            if (snap_d && ref_starve < STARVE) ref_starve++;
          end
          check("strobe_addr", {8'd0, flash_addr}, {8'd0, ea});
          owner_q.push_back(own);
          own_log.push_back(own);
          fl_addr     = flash_addr;
          fl_cnt      = $urandom_range(2, 0);
          fl_blen     = (fix_busy != 0) ? fix_busy : $urandom_range(4, 1);
          flash_rdata = $urandom;
          fl_phase    = 1;
        end
        1: begin
          check("strobe_width", {31'd0, flash_rstrobe}, 32'd0);
          if (fl_cnt == 0) begin flash_rbusy = 1'b1; fl_phase = 2; end
          else fl_cnt--;
        end
        2: begin
          check("addr_stable", {8'd0, flash_addr}, {8'd0, fl_addr});
          if (fl_blen <= 1) begin
            flash_rbusy = 1'b0;
            flash_rdata = fdat(fl_addr);
            fl_phase    = 0;
          end else fl_blen--;
        end
        default: begin
          check("stale_busy_strobe", {31'd0, flash_rstrobe}, 32'd0);
          if (fl_cnt == 0) begin flash_rbusy = 1'b0; fl_phase = 0; end
          else fl_cnt--;
        end
      endcase
    end
  end

  // Response monitor: pops expectations whenever a valid is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_valid && d_valid) check("both_valid", 32'd1, 32'd0);
      if (if_valid) begin
        if (if_exp.size() == 0 || owner_q.size() == 0) check("if_unexpected", 32'd1, 32'd0);
        else begin
          check("if_rdata", if_rdata, if_exp.pop_front());
          check("if_owner", 32'd0, {31'd0, owner_q.pop_front()});
          check("if_first_at_valid", {31'd0, if_first}, 32'd1);
        end
      end
      if (d_valid) begin
        if (d_exp.size() == 0 || owner_q.size() == 0) check("d_unexpected", 32'd1, 32'd0);
        else begin
          check("d_rdata", d_rdata, d_exp.pop_front());
          check("d_owner", 32'd1, {31'd0, owner_q.pop_front()});
          check("if_first_at_dvalid", {31'd0, if_first}, 32'd0);
        end
      end
    end
  end

  task automatic if_txn(input logic [ADDR_W-1:0] a, input bit hold);
    int c = 0;
    if_req = 1'b1;
    if_addr = a;
    if_exp.push_back(fdat(a));
    do begin @(negedge clk); c++; end while (!if_valid && c < TMO);
    if (!if_valid) check("if_timeout", 32'd0, 32'd1);
    if (!hold) if_req = 1'b0;
  endtask

  task automatic d_txn(input logic [ADDR_W-1:0] a, input bit hold);
    int c = 0;
    d_req = 1'b1;
    d_addr = a;
    d_exp.push_back(fdat(a));
    do begin @(negedge clk); c++; end while (!d_valid && c < TMO);
    if (!d_valid) check("d_timeout", 32'd0, 32'd1);
    if (!hold) d_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, c, nv;
    logic [4:0] pat;
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; if_addr = '0; d_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_d_valid", {31'd0, d_valid}, 32'd0);
    check("rst_if_first", {31'd0, if_first}, 32'd0);
    check("rst_rstrobe", {31'd0, flash_rstrobe}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_flash_addr", {8'd0, flash_addr}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single fetch, fixed 3-cycle busy.
    fix_busy = 3;
    s = n_strobe;
    if_txn(24'h400000, 1'b0);
    check("single_strobes", n_strobe - s, 32'd1);
    fix_busy = 0;
    repeat (2) @(negedge clk);

    // Simultaneous requests: ifetch first, then data.
    own_log.delete();
    fork
      if_txn(24'h400200, 1'b0);
      d_txn(24'h400100, 1'b0);
    join
    check("simul_order", {30'd0, own_log[0], own_log[1]}, 32'd1);
    repeat (2) @(negedge clk);

    // Starvation: both held continuously.
    own_log.delete();
    fork
      for (int k = 0; k < 10; k++) if_txn(24'h200000 + 24'(4 * k), k < 9);
      for (int k = 0; k < 3; k++) d_txn(24'h300000 + 24'(4 * k), k < 2);
    join
    pat = {own_log[0], own_log[1], own_log[2], own_log[3], own_log[4]};
    check("starve_pattern", {27'd0, pat}, 32'd1);
    check("starve_resume", {31'd0, own_log[5]}, 32'd0);
    repeat (2) @(negedge clk);

    // Request dropped during WAIT_BUSY still completes.
    if_req = 1'b1; if_addr = 24'h400400; if_exp.push_back(fdat(24'h400400));
    c = 0;
    while (!flash_rstrobe && c < TMO) begin @(negedge clk); c++; end
    check("drop_strobe", {31'd0, flash_rstrobe}, 32'd1);
    @(negedge clk);
    if_req = 1'b0;
    nv = 0;
    repeat (30) begin @(negedge clk); if (if_valid) nv++; end
    check("drop_valid_count", nv, 32'd1);

    // Reset during WAIT_DONE abandons the transaction.
    fix_busy = 4;
    if_req = 1'b1; if_addr = 24'h400300;
    c = 0;
    while (fl_phase != 2 && c < TMO) begin @(negedge clk); c++; end
    @(negedge clk);
    rst_n = 1'b0; if_req = 1'b0;
    @(negedge clk);
    owner_q.delete();
    check("midrst_if_valid", {31'd0, if_valid}, 32'd0);
    check("midrst_if_first", {31'd0, if_first}, 32'd0);
    check("midrst_flash_addr", {8'd0, flash_addr}, 32'd0);
    check("midrst_if_rdata", if_rdata, 32'd0);
    rst_n = 1'b1;
    fix_busy = 0;
    repeat (6) @(negedge clk);
    if_txn(24'h400304, 1'b0);
    repeat (2) @(negedge clk);

    // Repeated fetch of one address: cache build reads flash once.
    s = n_strobe;
    if_txn(24'h400004, 1'b0);
    @(negedge clk);
`ifdef FLASH_ARB_IFETCH_CACHE_EN
    owner_q.push_back(1'b0);
`endif
    if_txn(24'h400004, 1'b0);
    check("cache_strobes", n_strobe - s, EXP_CACHE_STROBES);
    repeat (2) @(negedge clk);

    // Randomized traffic on both requesters.
    fork
      begin
        bit h = 1'b0;
        for (int k = 0; k < 20; k++) begin
          if (!h) repeat ($urandom_range(3, 0)) @(negedge clk);
          h = (k < 19) && ($urandom_range(1, 0) == 1);
          if_txn(24'h100000 + 24'(4 * k), h);
        end
      end
      begin
        bit h = 1'b0;
        for (int k = 0; k < 12; k++) begin
          if (!h) repeat ($urandom_range(4, 0)) @(negedge clk);
          h = (k < 11) && ($urandom_range(1, 0) == 1);
          d_txn(24'($urandom), h);
        end
      end
    join
    repeat (4) @(negedge clk);
    check("queues_drained", if_exp.size() + d_exp.size() + owner_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
